// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: bus widths, default geometry,
// FSM state encoding and a small address helper.
package icache_pkg;

  // Instruction address and instruction word buses
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  // Default cache geometry: 2^7 one-word lines over an 18-bit physical space
  localparam int unsigned IC_INDEX_W  = 7;
  localparam int unsigned IC_ADDR_W   = 18;
  localparam int unsigned IC_TAG_W    = IC_ADDR_W - IC_INDEX_W - 2;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;

  // Clear the byte offset of a fetch address
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/data/valid storage for the direct-mapped icache.
// Ports:
//   clk_in, rst_in   clock and synchronous active-high reset (clears valid bits only)
//   i_rdy            global ready; writes are suppressed while low
//   i_we             fill strobe; writes tag/data and sets valid at i_wr_index
//   i_wr_index/tag/data  fill payload
//   i_rd_index/tag   combinational lookup address
//   o_hit_c          line valid and tag matches
//   o_rd_data_c      data word at i_rd_index
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = IC_INDEX_W,
  parameter int unsigned TAG_BITS   = IC_TAG_W,
  parameter int unsigned DATA_BITS  = INST_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  i_rdy,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [DATA_BITS-1:0]  i_wr_data,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_BITS-1:0]   i_rd_tag,
  output logic                  o_hit_c,
  output logic [DATA_BITS-1:0]  o_rd_data_c
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [DEPTH];
  logic [DATA_BITS-1:0] r_data [DEPTH];

  // Valid bits: the only reset storage
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= '0;
    end else if (i_rdy && i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk_in) begin
    if (i_rdy && i_we && !rst_in) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  // Combinational lookup
  assign o_hit_c     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data_c = r_data[i_rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache between If and mem_ctrl.
// Hits return one cycle after the request; misses fetch one word from
// mem_ctrl, fill the line and then deliver. A flush during a miss kills the
// delivery but the fill still completes.
// Ports:
//   clk_in, rst_in, rdy_in     clock, sync active-high reset, global ready
//   inst_req, pc_i, flush      request from If, fetch address, redirect from ex
//   inst_o, inst_ok            registered instruction word and 1-cycle valid pulse
//   mem_req, mem_pc            registered fetch request/address to mem_ctrl
//   mem_inst_i, mem_ok         returned word and its 1-cycle valid pulse
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = IC_INDEX_W,
  parameter int unsigned ADDR_BITS  = IC_ADDR_W
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   inst_req,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic                   flush,
  output logic [INST_W-1:0]      inst_o,
  output logic                   inst_ok,
  output logic                   mem_req,
  output logic [INST_ADDR_W-1:0] mem_pc,
  input  logic [INST_W-1:0]      mem_inst_i,
  input  logic                   mem_ok
);

  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  ic_state_e               r_state,      w_state_nxt;
  logic [INST_W-1:0]       r_inst_o,     w_inst_o_nxt;
  logic                    r_inst_ok,    w_inst_ok_nxt;
  logic                    r_mem_req,    w_mem_req_nxt;
  logic [INST_ADDR_W-1:0]  r_mem_pc,     w_mem_pc_nxt;
  logic                    r_kill,       w_kill_nxt;
  logic [INDEX_BITS-1:0]   r_miss_index, w_miss_index_nxt;
  logic [TAG_BITS-1:0]     r_miss_tag,   w_miss_tag_nxt;

  logic [INDEX_BITS-1:0]   w_index;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_hit;
  logic [INST_W-1:0]       w_hit_data;
  logic                    w_fill;
  logic [1:0]              w_unused_pc;

  // Address split of the incoming fetch address
  assign w_index     = pc_i[INDEX_BITS+1:2];
  assign w_tag       = pc_i[ADDR_BITS-1:INDEX_BITS+2];
  assign w_unused_pc = pc_i[1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_BITS  (INST_W)
  ) u_array (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_rdy       (rdy_in),
    .i_we        (w_fill),
    .i_wr_index  (r_miss_index),
    .i_wr_tag    (r_miss_tag),
    .i_wr_data   (mem_inst_i),
    .i_rd_index  (w_index),
    .i_rd_tag    (w_tag),
    .o_hit_c     (w_hit),
    .o_rd_data_c (w_hit_data)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_inst_o_nxt     = r_inst_o;
    w_inst_ok_nxt    = 1'b0;
    w_mem_req_nxt    = r_mem_req;
    w_mem_pc_nxt     = r_mem_pc;
    w_kill_nxt       = r_kill;
    w_miss_index_nxt = r_miss_index;
    w_miss_tag_nxt   = r_miss_tag;
    w_fill           = 1'b0;

    case (r_state)
      IC_IDLE: begin
        // A request alongside flush carries a stale pc and is dropped
        if (inst_req && !flush) begin
          if (w_hit) begin
            w_inst_o_nxt  = w_hit_data;
            w_inst_ok_nxt = 1'b1;
          end else begin
            w_mem_req_nxt    = 1'b1;
            w_mem_pc_nxt     = word_align(pc_i);
            w_miss_index_nxt = w_index;
            w_miss_tag_nxt   = w_tag;
            w_kill_nxt       = 1'b0;
            w_state_nxt      = IC_MISS;
          end
        end
      end
      IC_MISS: begin
        if (flush) begin
          w_kill_nxt = 1'b1;
        end
        if (mem_ok) begin
          // Line is installed even when the delivery is killed
          w_fill        = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IC_IDLE;
          if (!r_kill && !flush) begin
            w_inst_o_nxt  = mem_inst_i;
            w_inst_ok_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IC_IDLE;
      end
    endcase
  end

  // State and output registers; everything freezes while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IC_IDLE;
      r_inst_o     <= '0;
      r_inst_ok    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_pc     <= '0;
      r_kill       <= 1'b0;
      r_miss_index <= '0;
      r_miss_tag   <= '0;
    end else if (rdy_in) begin
      r_state      <= w_state_nxt;
      r_inst_o     <= w_inst_o_nxt;
      r_inst_ok    <= w_inst_ok_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_pc     <= w_mem_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_miss_index <= w_miss_index_nxt;
      r_miss_tag   <= w_miss_tag_nxt;
    end
  end

  assign inst_o  = r_inst_o;
  assign inst_ok = r_inst_ok;
  assign mem_req = r_mem_req;
  assign mem_pc  = r_mem_pc;

endmodule
